// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner.
// Accepts a packed multi-digit segment word over valid/ready, holds one
// pending update and swaps it onto the display only at frame boundaries.
// Each digit slot starts with a blanking guard to suppress ghosting.
// Optional feature macro: SEG_SCAN_LZB_EN (leading-zero blanking).
module seg_scan_driver #(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 4,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGITS-1:0][6:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [6:0]             seg,
  output logic [DIGITS-1:0]      an,
  output logic                   frame_done
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GUARD_LAST = DW'(GUARD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_div;
  logic [IW-1:0]           r_idx;
  logic [DIGITS-1:0][6:0]  r_pend;
  logic                    r_pend_valid;
  logic [DIGITS-1:0][6:0]  r_disp;
  logic [6:0]              r_seg;
  logic [DIGITS-1:0]       r_an;

  logic                    w_div_wrap;
  logic                    w_boundary;
  logic                    w_xfer;
  logic                    w_commit;
  logic [6:0]              w_seg_on;
  logic [DIGITS-1:0]       w_onehot;

  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_boundary = w_div_wrap && (r_idx == IDX_LAST);
  assign s_ready    = !r_pend_valid && !rst;
  assign w_xfer     = s_valid && s_ready;
  // A commit needs something pending, a transfer needs nothing pending,
  // so the two never coincide on one edge.
  assign w_commit   = w_boundary && r_pend_valid;
  assign frame_done = w_boundary && !rst;
  assign seg        = r_seg;
  assign an         = r_an;

  // One-hot enable for the digit currently being scanned
  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] w_lz;

  // w_lz[k]: digit k and every more-significant digit show "0"
  always_comb begin
    w_lz             = '0;
    w_lz[DIGITS-1]   = (r_disp[DIGITS-1] == 7'b1111110);
    for (int k = DIGITS - 2; k >= 0; k--)
      w_lz[k] = (r_disp[k] == 7'b1111110) && w_lz[k+1];
  end

  // Segment pattern during ON, leading zeros blanked (ones digit always shown)
  always_comb begin
    w_seg_on = r_disp[r_idx];
    if ((r_idx != '0) && w_lz[r_idx]) w_seg_on = '0;
  end
`else
  // Segment pattern during ON, shown as-is
  always_comb begin
    w_seg_on = r_disp[r_idx];
  end
`endif

  // Slot divider and digit index; free-running from reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_div_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // One-deep pending buffer; swapped onto the display only at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_disp       <= '0;
    end else begin
      if (w_commit) begin
        r_disp       <= r_pend;
        r_pend_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_pend       <= s_data;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Scan FSM: stays IDLE until the first commit, then alternates guard/on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_commit) begin
          if (GUARD_CYC > 0) r_state <= GUARD;
          else               r_state <= ON;
        end
        GUARD: if (r_div == GUARD_LAST) r_state <= ON;
        ON: if (w_div_wrap && (GUARD_CYC > 0)) r_state <= GUARD;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Registered drive; polarity applied here so blank follows ACTIVE_LOW too
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= {7{POL}};
      r_an  <= {DIGITS{POL}};
    end else if (r_state == ON) begin
      r_seg <= w_seg_on ^ {7{POL}};
      r_an  <= w_onehot ^ {DIGITS{POL}};
    end else begin
      r_seg <= {7{POL}};
      r_an  <= {DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (active-high and active-low
// polarity) share one stimulus stream. The driver pushes the expected
// per-cycle outputs into a queue; a negedge monitor pops and compares.
module tb_seg_scan_driver;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic [1:0][6:0] s_data = '0;
  logic            s_ready, frame_done, s_ready2, frame_done2;
  logic [6:0]      seg, seg2;
  logic [1:0]      an, an2;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(2), .REFRESH_DIV(4), .GUARD_CYC(1), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .seg(seg), .an(an), .frame_done(frame_done));

  seg_scan_driver #(.DIGITS(2), .REFRESH_DIV(4), .GUARD_CYC(1), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
    .seg(seg2), .an(an2), .frame_done(frame_done2));

  typedef struct packed {
    logic       rdy;
    logic       fd;
    logic [6:0] seg;
    logic [1:0] an;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   mcyc   = 0;

  // Reference state: frame position 0..7, pending word, shown word
  int          m_f    = 0;
  logic        m_pv   = 1'b0;
  logic        m_act  = 1'b0;
  logic [13:0] m_pend = '0;
  logic [13:0] m_disp = '0;
  logic [6:0]  m_seg  = '0;
  logic [1:0]  m_an   = '0;
  logic        p_rst  = 1'b1;
  logic        p_v    = 1'b0;
  logic [13:0] p_d    = '0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // What the scanner drives for the state at frame position p
  // (div = p%4, idx = p/4, guard while div==0).
  function automatic void vis(input int p, input logic [13:0] d, input logic act,
                              output logic [6:0] s, output logic [1:0] a);
    s = '0;
    a = '0;
    if (act && (p % 4) != 0) begin
      if (p < 4) begin
        s = d[6:0];
        a = 2'b01;
      end else begin
        s = d[13:7];
        a = 2'b10;
`ifdef SEG_SCAN_LZB_EN
        if (d[13:7] == 7'b1111110) s = '0;
`endif
      end
    end
  endfunction

  // Advance one clock: update the reference across the edge, apply new
  // inputs, and queue what the outputs must show during this cycle.
  task automatic step(input logic r, input logic v, input logic [13:0] d, output logic acc);
    logic [6:0] ns;
    logic [1:0] na;
    exp_t       e;
    @(posedge clk);
    if (p_rst) begin
      m_f = 0; m_pv = 1'b0; m_act = 1'b0; m_seg = '0; m_an = '0;
    end else begin
      vis(m_f, m_disp, m_act, ns, na);
      m_seg = ns;
      m_an  = na;
      if (m_f == 7 && m_pv) begin
        m_disp = m_pend; m_pv = 1'b0; m_act = 1'b1;
      end else if (p_v && !m_pv) begin
        m_pend = p_d; m_pv = 1'b1;
      end
      m_f = (m_f + 1) % 8;
    end
    #1;
    rst = r; s_valid = v; s_data = d;
    p_rst = r; p_v = v; p_d = d;
    e.rdy = !m_pv && !r;
    e.fd  = (m_f == 7) && !r;
    e.seg = m_seg;
    e.an  = m_an;
    q.push_back(e);
    acc = v && e.rdy;
  endtask

  // Monitor: one expectation per cycle, checked on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mcyc++;
      chk("s_ready",     {15'd0, s_ready},     {15'd0, mon_e.rdy});
      chk("frame_done",  {15'd0, frame_done},  {15'd0, mon_e.fd});
      chk("seg",         {9'd0, seg},          {9'd0, mon_e.seg});
      chk("an",          {14'd0, an},          {14'd0, mon_e.an});
      chk("al_s_ready",  {15'd0, s_ready2},    {15'd0, mon_e.rdy});
      chk("al_frame",    {15'd0, frame_done2}, {15'd0, mon_e.fd});
      chk("al_seg",      {9'd0, seg2},         {9'd0, ~mon_e.seg});
      chk("al_an",       {14'd0, an2},         {14'd0, ~mon_e.an});
    end
  end

  localparam logic [13:0] WA  = {7'b0110000, 7'b1101101};  // "12"
  localparam logic [13:0] WB  = {7'b1111001, 7'b0110011};  // "34"
  localparam logic [13:0] W8  = {7'b1111110, 7'b1111111};  // "08"
  localparam logic [13:0] W05 = {7'b1111110, 7'b1011011};  // "05"
  logic [13:0] words [4];
  logic        acc;
  int          widx;
  logic [6:0]  exp_tens;

  initial begin
    words[0] = {7'b1011011, 7'b1011111};
    words[1] = {7'b1110000, 7'b1111011};
    words[2] = {7'b0110011, 7'b1111110};
    words[3] = {7'b1001111, 7'b0110000};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, acc);

    // Word A accepted at once; B offered while A is pending, lands at cycle 8
    for (int n = 0; n < 24; n++) begin
      step(1'b0, n < 9, (n == 0) ? WA : WB, acc);
      if (n == 0) begin
        @(negedge clk);
        chk("c0_accept", {15'd0, acc}, 16'd1);
      end
      if (n == 1) begin
        @(negedge clk);
        chk("c1_busy", {15'd0, s_ready}, 16'd0);
      end
      if (n == 7) begin
        @(negedge clk);
        chk("c7_frame_done", {15'd0, frame_done}, 16'd1);
      end
      if (n == 8) begin
        @(negedge clk);
        chk("c8_ready", {15'd0, s_ready}, 16'd1);
      end
      if (n == 9) begin
        @(negedge clk);
        chk("c9_guard_an", {14'd0, an}, 16'd0);
      end
      if (n == 10) begin
        @(negedge clk);
        chk("c10_seg", {9'd0, seg}, {9'd0, 7'b1101101});
        chk("c10_an",  {14'd0, an}, 16'h0001);
      end
      if (n == 14) begin
        @(negedge clk);
        chk("c14_seg", {9'd0, seg}, {9'd0, 7'b0110000});
        chk("c14_an",  {14'd0, an}, 16'h0002);
      end
    end

    // Valid held; a fresh word after every transfer
    widx = 0;
    for (int n = 0; n < 32; n++) begin
      step(1'b0, 1'b1, words[widx % 4], acc);
      if (acc) widx++;
    end
    chk("one_xfer_per_frame", 16'(widx), 16'd4);

    // Reset pulse in the middle of an ON slot
    step(1'b0, 1'b0, '0, acc);
    step(1'b0, 1'b0, '0, acc);
    step(1'b1, 1'b1, WB, acc);
    @(negedge clk);
    chk("rst_ready_low", {15'd0, s_ready}, 16'd0);

    // Active-low "8", then "05" for leading-zero behaviour
`ifdef SEG_SCAN_LZB_EN
    exp_tens = 7'b0000000;
`else
    exp_tens = 7'b1111110;
`endif
    for (int m = 0; m < 40; m++) begin
      step(1'b0, (m == 0) || (m == 16), (m == 16) ? W05 : W8, acc);
      if (m == 0) begin
        @(negedge clk);
        chk("post_rst_seg",   {9'd0, seg},  16'd0);
        chk("post_rst_an",    {14'd0, an},  16'd0);
        chk("post_rst_ready", {15'd0, s_ready}, 16'd1);
      end
      if (m == 5) begin
        @(negedge clk);
        chk("idle_blank_an", {14'd0, an}, 16'd0);
      end
      if (m == 9) begin
        @(negedge clk);
        chk("al_guard_an",  {14'd0, an2},  16'h0003);
        chk("al_guard_seg", {9'd0, seg2},  {9'd0, 7'b1111111});
      end
      if (m == 10) begin
        @(negedge clk);
        chk("al_eight_seg", {9'd0, seg2}, 16'd0);
        chk("al_eight_an",  {14'd0, an2}, 16'h0002);
      end
      if (m == 26) begin
        @(negedge clk);
        chk("lz_ones_seg", {9'd0, seg}, {9'd0, 7'b1011011});
      end
      if (m == 30) begin
        @(negedge clk);
        chk("lz_tens_seg", {9'd0, seg}, {9'd0, exp_tens});
        chk("lz_tens_an",  {14'd0, an}, 16'h0002);
      end
    end

    @(negedge clk);
    @(posedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout @%0t got running expected finished", $time);
    $fatal(1);
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream consumer of the decimal-sum/seven-segment stage. Accepts a packed multi-digit seven-segment word over a valid/ready handshake, buffers one pending update, and time-multiplexes the digits onto a single segment bus with one-hot digit enables. Updates are committed only at scan-frame boundaries (tear-free), with a blanking guard at the start of each digit slot (anti-ghosting).

Parameters:
DIGITS, 2, number of digits scanned; index 0 = ones (least significant).
REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2.
GUARD_CYC, 4, blanked cycles at start of each slot; must be < REFRESH_DIV.
ACTIVE_LOW, 0, 1 inverts both seg and an at the output registers.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
s_data  in  [DIGITS-1:0][6:0]  segment patterns; bit6=a ... bit0=g; 1 = segment lit (before polarity).
s_valid  in  1  upstream data valid.
s_ready  out  1  block can accept s_data.
seg  out  7  segment drive for the active digit, registered.
an  out  DIGITS  one-hot digit enable, registered.
frame_done  out  1  one-cycle pulse on the last cycle of every frame.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. All state clears on the clk edge at which rst is sampled high.
- Reset values: seg=0, an=0 (inverted if ACTIVE_LOW), frame_done=0, pend_valid=0, div=0, idx=0, state=IDLE.
  - s_ready=0 while rst is high; 1 on the first cycle after.
- Handshake: s_ready = !pend_valid && !rst.
  - Transfer on s_valid && s_ready: pend <= s_data, pend_valid <= 1.
  - s_data is ignored when no transfer occurs. Upstream holds data while s_ready=0.
- Slot timing:
  - div counts 0..REFRESH_DIV-1 and wraps, width $clog2(REFRESH_DIV).
  - On wrap, idx increments 0..DIGITS-1 and wraps.
  - Frame boundary: div==REFRESH_DIV-1 && idx==DIGITS-1. frame_done is high on that cycle.
- Commit: at a frame boundary with pend_valid=1, disp <= pend and pend_valid <= 0. s_ready rises the next cycle.
  - A transfer on the boundary cycle itself is not committed until the following boundary.
- FSM:
  - IDLE: counters run; an and seg are blank. Go to GUARD on the first commit.
  - GUARD: active while div < GUARD_CYC. an blank, seg blank.
  - ON: an = one-hot(idx), seg = disp[idx].
  - GUARD -> ON when div==GUARD_CYC-1. ON -> GUARD on div wrap.
  - Never returns to IDLE except via rst.
- Output latency: seg/an are registered, one cycle after the div/idx/state values that select them.
- A new commit changes the displayed digit only from slot idx=0 of the next frame onward. No partial frame ever shows mixed data.
- Reset mid-frame: all outputs blank on the next edge; any pending update is discarded.

Optional Feature:
SEG_SCAN_LZB_EN: leading-zero blanking.
- When defined: during ON, digit k>0 is blanked (seg=0) if disp[k] and all higher digits equal 7'b1111110 ("0"). Digit 0 always displays. an is still asserted for the blanked digit.
- When undefined: all digits are displayed as-is.

Test Plan:
1. REFRESH_DIV=4, GUARD_CYC=1. Release rst; drive s_data={7'b0110000,7'b1101101} (tens "1", ones "2") with s_valid=1 -> accepted on the first cycle (s_ready=1), s_ready low until the frame boundary at cycle 7. Then slot 0: an=01 (blank 1 cycle), seg=1101101 for 3 cycles; slot 1: an=10, seg=0110000.
2. Second word offered mid-frame while pend_valid=1 -> s_ready=0, no acceptance. Committed word is displayed unchanged until the next boundary; frame_done pulses once every 8 cycles.
3. s_valid held 1 with a new word each transfer -> exactly one transfer per frame. Display never mixes digits of two words within one frame.
4. Assert rst for 1 cycle mid ON-slot -> next cycle seg=0, an=0, s_ready=0. Then s_ready=1, state=IDLE, outputs blank until a new commit.
5. ACTIVE_LOW=1, digit "8" (7'b1111111) on ones -> seg=0000000, an=10 for slot 0; guard cycles show an=11, seg=1111111.
6. SEG_SCAN_LZB_EN defined, s_data={7'b1111110,7'b1011011} ("05") -> slot 1 seg=0000000 with an=10; slot 0 seg=1011011. Undefined -> slot 1 seg=1111110.
